// File: rtl/data_sram_responder_pkg.sv
// Shared constants and types for the data SRAM responder: region bases,
// configuration register offsets and the address-decode result.
package data_sram_responder_pkg;

  localparam logic [31:0] RAM_BASE  = 32'h1c00_0000;
  localparam logic [31:0] CONF_BASE = 32'hbfaf_0000;

  localparam logic [15:0] OFS_LED     = 16'h0000;
  localparam logic [15:0] OFS_SWITCH  = 16'h0004;
  localparam logic [15:0] OFS_TIMER   = 16'h0008;
  localparam logic [15:0] OFS_SCRATCH = 16'h000C;
  localparam logic [15:0] OFS_WCOUNT  = 16'h0010;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_CONF,
    REG_NONE
  } region_e;

endpackage

// File: rtl/data_sram_responder_conf_regs.sv
// Configuration/MMIO register bank: LED, synchronized switches, free-running
// timer, scratch and a saturating count of mapped writes.
module data_sram_responder_conf_regs
  import data_sram_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        count_en,
  input  logic [15:0] offset,
  input  logic [31:0] wdata,
  input  logic [7:0]  switch,
  output logic [31:0] rdata,
  output logic [15:0] led
);

  logic [7:0]  switch_meta;
  logic [7:0]  switch_sync;
  logic [31:0] timer;
  logic [31:0] scratch;
  logic [31:0] wcount;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      switch_meta <= '0;
      switch_sync <= '0;
      led         <= '0;
      timer       <= '0;
      scratch     <= '0;
      wcount      <= '0;
    end else begin
      switch_meta <= switch;
      switch_sync <= switch_meta;
      if (we && offset == OFS_LED)     led     <= wdata[15:0];
      if (we && offset == OFS_SCRATCH) scratch <= wdata;
      // A load takes the place of that cycle's increment.
      timer <= (we && offset == OFS_TIMER) ? wdata : timer + 32'd1;
      if (count_en && wcount != 32'hFFFF_FFFF) wcount <= wcount + 32'd1;
    end
  end

  // NOTE: the default assignment before the case keeps this purely
  // combinational; an unassigned path would infer a latch.
  always_comb begin
    rdata = '0;
    case (offset)
      OFS_LED:     rdata = {16'b0, led};
      OFS_SWITCH:  rdata = {24'b0, switch_sync};
      OFS_TIMER:   rdata = timer;
      OFS_SCRATCH: rdata = scratch;
      OFS_WCOUNT:  rdata = wcount;
      default:     rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data SRAM port: decodes RAM / config /
// unmapped space and returns read-first data with one cycle of latency.
module data_sram_responder #(
  parameter int unsigned RAM_DEPTH = 4096,
  parameter logic [31:0] RAM_BASE  = data_sram_responder_pkg::RAM_BASE,
  parameter logic [31:0] CONF_BASE = data_sram_responder_pkg::CONF_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        err_pulse,
  output logic        err_seen
);

  import data_sram_responder_pkg::*;

  localparam int unsigned IDX_W = $clog2(RAM_DEPTH);

  region_e           region;
  logic [31:0]       word_ofs;
  logic              ram_in_range;
  logic [IDX_W-1:0]  ram_idx;
  logic              ram_we;
  logic              conf_we;
  logic              mapped_we;
  logic [31:0]       conf_rdata;
  logic [31:0]       read_data;
  logic [31:0]       ram [RAM_DEPTH];
  logic              unused_addr_bits;

  assign unused_addr_bits = ^data_sram_addr[1:0];

  // Range check on the full 32-bit word offset, then truncate to the index.
  assign word_ofs     = {2'b00, data_sram_addr[31:2]} - {2'b00, RAM_BASE[31:2]};
  assign ram_in_range = word_ofs < RAM_DEPTH;
  assign ram_idx      = word_ofs[IDX_W-1:0];

  always_comb begin
    region = REG_NONE;
    if (data_sram_addr[31:16] == CONF_BASE[31:16])
      region = REG_CONF;
    else if (data_sram_addr[31:16] == RAM_BASE[31:16] && ram_in_range)
      region = REG_RAM;
  end

  assign conf_we   = data_sram_we && region == REG_CONF;
  assign mapped_we = data_sram_we && region != REG_NONE;
  // The array has no reset, so block writes while reset is held.
  assign ram_we    = data_sram_we && region == REG_RAM && !reset;

  // NOTE: the RAM array is deliberately not reset; clearing it would turn the
  // memory into thousands of flops instead of an inferable RAM.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= data_sram_wdata;
  end

  data_sram_responder_conf_regs u_conf_regs (
    .clk      (clk),
    .reset    (reset),
    .we       (conf_we),
    .count_en (mapped_we),
    .offset   ({data_sram_addr[15:2], 2'b00}),
    .wdata    (data_sram_wdata),
    .switch   (switch),
    .rdata    (conf_rdata),
    .led      (led)
  );

  always_comb begin
    read_data = '0;
    case (region)
      REG_RAM:  read_data = ram[ram_idx];
      REG_CONF: read_data = conf_rdata;
      default:  read_data = '0;
    endcase
  end

  // Read data is captured at the same edge as any write, giving read-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sram_rdata <= '0;
      err_pulse       <= 1'b0;
      err_seen        <= 1'b0;
    end else begin
      data_sram_rdata <= read_data;
      err_pulse       <= region == REG_NONE;
      err_seen        <= err_seen | (region == REG_NONE);
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized self-checking bench for data_sram_responder against a
// behavioural model built from region, timer and counter rules.
module tb_data_sram_responder;
  import data_sram_responder_pkg::*;

  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic        err_pulse;
  logic        err_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (switch),
    .led             (led),
    .err_pulse       (err_pulse),
    .err_seen        (err_seen)
  );

  // Reference model state.
  logic [31:0]     ram_m [int unsigned];
  logic [7:0]      sw_hist [$];
  logic [15:0]     led_m;
  logic [31:0]     scratch_m;
  logic [31:0]     tmr_val;
  int              tmr_edge;
  int              edge_n;
  longint unsigned wcnt_m;
  logic            err_seen_m;

  logic [31:0] pool [8] = '{32'h1c00_0000, 32'h1c00_0004, 32'h1c00_0008, 32'h1c00_0010,
                            32'h1c00_0020, 32'h1c00_0040, 32'h1c00_1000, 32'h1c00_3ffc};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    sw_hist    = '{8'h00, 8'h00};
    led_m      = '0;
    scratch_m  = '0;
    tmr_val    = '0;
    tmr_edge   = -1;
    edge_n     = 0;
    wcnt_m     = 0;
    err_seen_m = 1'b0;
  endtask

  // One rising edge of the model: returns what the DUT must present next.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rd, output logic exp_err);
    logic [31:0] timer_now;
    logic [15:0] ofs;
    int unsigned widx;
    bit          is_conf;
    bit          is_ram;
    timer_now = tmr_val + 32'(edge_n - tmr_edge - 1);
    ofs       = a[15:0] & 16'hFFFC;
    widx      = (a >> 2) - (RAM_BASE >> 2);
    is_conf   = (a >> 16) == (CONF_BASE >> 16);
    is_ram    = !is_conf && (a >> 16) == (RAM_BASE >> 16) && widx < DEPTH;
    exp_rd    = '0;
    exp_err   = !is_conf && !is_ram;
    if (is_ram) begin
      if (ram_m.exists(widx)) exp_rd = ram_m[widx];
      if (w) ram_m[widx] = d;
    end else if (is_conf) begin
      case (ofs)
        16'h0000: exp_rd = 32'(led_m);
        16'h0004: exp_rd = 32'(sw_hist[0]);
        16'h0008: exp_rd = timer_now;
        16'h000C: exp_rd = scratch_m;
        16'h0010: exp_rd = (wcnt_m > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : wcnt_m[31:0];
        default:  exp_rd = '0;
      endcase
      if (w && ofs == 16'h0000) led_m = d[15:0];
      if (w && ofs == 16'h000C) scratch_m = d;
      if (w && ofs == 16'h0008) begin
        tmr_val  = d;
        tmr_edge = edge_n;
      end
    end
    if (w && (is_conf || is_ram)) wcnt_m++;
    if (exp_err) err_seen_m = 1'b1;
    sw_hist.push_back(switch);
    void'(sw_hist.pop_front());
    edge_n++;
  endtask

  task automatic do_access(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d);
    logic [31:0] exp_rd;
    logic        exp_err;
    we    = w;
    addr  = a;
    wdata = d;
    model_access(w, a, d, exp_rd, exp_err);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".rdata"}, rdata, exp_rd);
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(exp_err));
    check({tag, ".err_seen"}, 32'(err_seen), 32'(err_seen_m));
    check({tag, ".led"}, 32'(led), 32'(led_m));
  endtask

  initial begin
    logic [31:0] a;
    reset  = 1'b1;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    switch = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.rdata", rdata, 32'h0);
    check("reset.led", 32'(led), 32'h0);
    check("reset.err_seen", 32'(err_seen), 32'h0);
    check("reset.err_pulse", 32'(err_pulse), 32'h0);
    reset = 1'b0;

    // First post-reset access sees a zero timer.
    do_access("tmr_first", 1'b0, CONF_BASE + 32'(OFS_TIMER), '0);

    foreach (pool[i]) do_access("init", 1'b1, pool[i], $urandom);

    do_access("ram_wr", 1'b1, 32'h1c00_0010, 32'hDEAD_BEEF);
    do_access("ram_rd", 1'b0, 32'h1c00_0010, '0);
    do_access("ram_rd_lowbits", 1'b0, 32'h1c00_0013, '0);

    do_access("rf_setup", 1'b1, 32'h1c00_0020, 32'h1111_1111);
    do_access("rf_wr", 1'b1, 32'h1c00_0020, 32'h2222_2222);
    do_access("rf_rd", 1'b0, 32'h1c00_0020, '0);

    do_access("wc_before", 1'b0, CONF_BASE + 32'(OFS_WCOUNT), '0);
    do_access("led_wr", 1'b1, CONF_BASE + 32'(OFS_LED), 32'hFFFF_A5A5);
    do_access("led_rd", 1'b0, CONF_BASE + 32'(OFS_LED), '0);
    do_access("wc_after", 1'b0, CONF_BASE + 32'(OFS_WCOUNT), '0);
    do_access("wc_ro_wr", 1'b1, CONF_BASE + 32'(OFS_WCOUNT), 32'h1234_5678);
    do_access("wc_ro_rd", 1'b0, CONF_BASE + 32'(OFS_WCOUNT), '0);

    do_access("tmr_wr", 1'b1, CONF_BASE + 32'(OFS_TIMER), 32'hFFFF_FFFE);
    for (int i = 0; i < 4; i++) do_access("tmr_rd", 1'b0, CONF_BASE + 32'(OFS_TIMER), '0);

    switch = 8'h3C;
    for (int i = 0; i < 4; i++) do_access("sw_rd", 1'b0, CONF_BASE + 32'(OFS_SWITCH), '0);
    do_access("sw_ro_wr", 1'b1, CONF_BASE + 32'(OFS_SWITCH), 32'hFFFF_FFFF);

    do_access("hole_wr", 1'b1, CONF_BASE + 32'h14, 32'hCAFE_F00D);
    do_access("hole_rd", 1'b0, CONF_BASE + 32'h14, '0);

    do_access("ram_top_wr", 1'b1, 32'h1c00_3ffc, 32'h0BAD_CAFE);
    do_access("ram_top_rd", 1'b0, 32'h1c00_3ffc, '0);
    do_access("ram_past_wr", 1'b1, 32'h1c00_4000, 32'h5A5A_5A5A);
    do_access("ram_past_rd", 1'b0, 32'h1c00_4000, '0);

    do_access("unm_wr", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    do_access("unm_rd", 1'b0, 32'h8000_0000, '0);
    do_access("unm_after_ram", 1'b0, 32'h1c00_0010, '0);
    do_access("unm_after_led", 1'b0, CONF_BASE + 32'(OFS_LED), '0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) switch = 8'($urandom);
      case ($urandom_range(0, 3))
        0, 1: a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
        2:    a = CONF_BASE + 32'($urandom_range(0, 7) * 4);
        default: begin
          case ($urandom_range(0, 2))
            0:       a = {16'h8000, 16'($urandom)};
            1:       a = 32'h1c00_4000 + 32'($urandom_range(0, 16'h2fff) << 2);
            default: a = {16'hbfae, 16'($urandom)};
          endcase
        end
      endcase
      do_access("rand", 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Bring the timer near 0x100 with LED at 0x00FF, then reset mid-cycle.
    do_access("pre_tmr", 1'b1, CONF_BASE + 32'(OFS_TIMER), 32'h0000_00F8);
    do_access("pre_led", 1'b1, CONF_BASE + 32'(OFS_LED), 32'h0000_00FF);
    do_access("pre_unm", 1'b0, 32'h0000_1000, '0);
    for (int i = 0; i < 5; i++) do_access("pre_rd", 1'b0, CONF_BASE + 32'(OFS_LED), '0);
    #2 reset = 1'b1;
    #1;
    check("async_rst.rdata", rdata, 32'h0);
    check("async_rst.led", 32'(led), 32'h0);
    check("async_rst.err_seen", 32'(err_seen), 32'h0);
    check("async_rst.err_pulse", 32'(err_pulse), 32'h0);
    we    = 1'b1;
    addr  = pool[0];
    wdata = 32'h5555_5555;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_access("post_tmr", 1'b0, CONF_BASE + 32'(OFS_TIMER), '0);
    do_access("post_ram", 1'b0, pool[0], '0);
    do_access("post_wc", 1'b0, CONF_BASE + 32'(OFS_WCOUNT), '0);
    do_access("post_scr", 1'b0, CONF_BASE + 32'(OFS_SCRATCH), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
